// File: rtl/disp_sched_pkg.sv
// Shared definitions for the display scheduler.
//   state_t     : scheduler FSM encoding (IDLE / OWN)
//   DIGIT_W     : width of one BCD digit
//   DISP_DIGITS : digits on the display
//   WORD_W      : width of one client's digit word {d3,d2,d1,d0}
package disp_sched_pkg;

  localparam int DIGIT_W     = 4;
  localparam int DISP_DIGITS = 4;
  localparam int WORD_W      = DIGIT_W * DISP_DIGITS;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

endpackage

// File: rtl/disp_sched_rr_arbiter.sv
// Combinational round-robin pick.
//   req      : request vector
//   ptr      : index where the search starts; the search wraps past N-1 to 0
//   pick     : one-hot winner, zero when nothing requests
//   pick_idx : binary index of the winner (0 when nothing requests)
//   valid    : some request was found
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] pick_idx,
  output logic          valid
);

  // Two passes instead of a modulo index: first the slots at or above ptr,
  // then the wrapped slots below it.
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i] && (i >= int'(ptr))) begin
        pick[i]  = 1'b1;
        pick_idx = PW'(i);
        valid    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i] && (i < int'(ptr))) begin
        pick[i]  = 1'b1;
        pick_idx = PW'(i);
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_sched.sv
// Shares the 4-digit 7-segment driver between N_REQ clients with round-robin
// arbitration, a minimum ownership time and per-client blink.
//   clk, rst_n   : clock, asynchronous active-low reset
//   tick         : one-clk timebase strobe for hold and blink counters
//   req, blink   : per-client request level and blink request
//   req_bcd      : client i digits at [16i+15:16i] = {d3,d2,d1,d0}
//   gnt          : one-hot owner, zero when idle
//   en_7seg      : display enable (blink applied here)
//   bcd0..bcd3   : owner's digits, one clock behind req_bcd; bcd0 = rightmost
//   busy         : some client owns the display
module disp_sched
  import disp_sched_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int HOLD_TICKS  = 8,
  parameter int BLINK_TICKS = 4,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          blink,
  input  logic [WORD_W*N_REQ-1:0]   req_bcd,
  output logic [N_REQ-1:0]          gnt,
  output logic                      en_7seg,
  output logic [DIGIT_W-1:0]        bcd0,
  output logic [DIGIT_W-1:0]        bcd1,
  output logic [DIGIT_W-1:0]        bcd2,
  output logic [DIGIT_W-1:0]        bcd3,
  output logic                      busy
);

  localparam int               PW         = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_TICKS);

  state_t           state;
  logic [PW-1:0]    owner;
  logic [PW-1:0]    rr_ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] blink_cnt;
  logic             phase;

  logic [N_REQ-1:0] pick;
  logic [PW-1:0]    pick_idx;
  logic             pick_valid;
  logic [PW-1:0]    after_owner;
  logic [PW-1:0]    arb_ptr;
  logic             owner_req;
  logic             do_grant;
  logic             do_idle;
  logic             phase_toggle;
  logic             phase_next;
  logic [WORD_W-1:0] owner_word;

  assign after_owner = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign owner_req   = req[owner];
  assign owner_word  = req_bcd[int'(owner)*WORD_W +: WORD_W];

  // In OWN the search starts just past the owner and the owner is masked
  // out, which covers both the release hand-off and the hold-expiry rotation.
  assign arb_ptr = (state == OWN) ? after_owner : rr_ptr;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req      (req & ~gnt),
    .ptr      (arb_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

  // Release takes priority over hold expiry; a grant reloads the counters,
  // so a coincident tick is ignored.
  assign do_grant = pick_valid &&
                    ((state == IDLE) || !owner_req || (hold_cnt == '0));
  assign do_idle  = (state == OWN) && !owner_req && !pick_valid;

  // The blink phase runs whether or not the owner currently asks for blink.
  assign phase_toggle = tick && (blink_cnt <= CNT_W'(1));
  assign phase_next   = phase ^ phase_toggle;

  // NOTE: registers use non-blocking assignments so every right-hand side
  // sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      en_7seg   <= 1'b0;
      busy      <= 1'b0;
      {bcd3, bcd2, bcd1, bcd0} <= '0;
    end else begin
      if ((state == OWN) && !owner_req) rr_ptr <= after_owner;

      // Digits always follow the owner of the current cycle.
      if ((state == OWN) && !do_idle) {bcd3, bcd2, bcd1, bcd0} <= owner_word;
      else                            {bcd3, bcd2, bcd1, bcd0} <= '0;

      if (do_grant) begin
        state     <= OWN;
        gnt       <= pick;
        owner     <= pick_idx;
        hold_cnt  <= HOLD_LOAD;
        blink_cnt <= BLINK_LOAD;
        phase     <= 1'b1;
        en_7seg   <= 1'b1;
        busy      <= 1'b1;
      end else if ((state == IDLE) || do_idle) begin
        state     <= IDLE;
        gnt       <= '0;
        hold_cnt  <= '0;
        blink_cnt <= '0;
        phase     <= 1'b0;
        en_7seg   <= 1'b0;
        busy      <= 1'b0;
      end else begin
        if (tick && (hold_cnt != '0)) hold_cnt <= hold_cnt - 1'b1;
        if (phase_toggle)   blink_cnt <= BLINK_LOAD;
        else if (tick)      blink_cnt <= blink_cnt - 1'b1;
        phase   <= phase_next;
        en_7seg <= blink[owner] ? phase_next : 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_disp_sched.sv
module tb_disp_sched;

  localparam logic [15:0] W0 = 16'h5678;
  localparam logic [15:0] W1 = 16'h1234;
  localparam logic [15:0] W2 = 16'hC2A9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [2:0]  req;
  logic [2:0]  blink;
  logic [47:0] req_bcd;
  logic [2:0]  gnt;
  logic        en_7seg;
  logic [3:0]  bcd0, bcd1, bcd2, bcd3;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [20:0] sb[$];
  logic [2:0]  prev_g = 3'b000;
  logic [20:0] exp_v;
  logic [20:0] got_v;

  disp_sched #(
    .N_REQ(3), .HOLD_TICKS(8), .BLINK_TICKS(4), .CNT_W(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .req     (req),
    .blink   (blink),
    .req_bcd (req_bcd),
    .gnt     (gnt),
    .en_7seg (en_7seg),
    .bcd0    (bcd0),
    .bcd1    (bcd1),
    .bcd2    (bcd2),
    .bcd3    (bcd3),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] word_of(input logic [2:0] g);
    case (g)
      3'b001:  return W0;
      3'b010:  return W1;
      3'b100:  return W2;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [20:0] obs();
    return {gnt, en_7seg, bcd3, bcd2, bcd1, bcd0, busy};
  endfunction

  // Expected {gnt, en, digits, busy}; digits lag the grant by one clock and
  // are zero whenever the display is idle now or was idle the cycle before.
  task automatic push_exp(input logic [2:0] g, input logic e);
    logic [15:0] w;
    w = ((g != 3'b000) && (prev_g != 3'b000)) ? word_of(prev_g) : 16'h0000;
    sb.push_back({g, e, w, |g});
    prev_g = g;
  endtask

  task automatic step(input logic tk);
    tick = tk;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tick = 1'b0; req = '0; blink = '0;
    req_bcd = {W2, W1, W0};
    #2;
    push_exp(3'b000, 1'b0);
    exp_v = sb.pop_front(); got_v = obs(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL reset_initial: got %h expected %h", got_v, exp_v);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    for (int i = 0; i < 4; i++) begin
      req = (i < 3) ? 3'b010 : 3'b000;
      push_exp((i < 3) ? 3'b010 : 3'b000, i < 3);
      step(1'b0);
      exp_v = sb.pop_front(); got_v = obs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL single step %0d: got %h expected %h", i, got_v, exp_v);
      end
    end
  endtask

  // Pointer is 2 here; the rotation lands on the same cycle as a tick, so
  // client 0 must hold for a full 8 ticks afterwards.
  task automatic test_wrap;
    logic [2:0] g;
    for (int i = 0; i < 20; i++) begin
      req = (i < 19) ? 3'b101 : 3'b000;
      g = (i <= 8) ? 3'b100 : (i <= 17) ? 3'b001 : (i == 18) ? 3'b100 : 3'b000;
      push_exp(g, g != 3'b000);
      step((i >= 1) && (i <= 17));
      exp_v = sb.pop_front(); got_v = obs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL wrap step %0d: got %h expected %h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_contention;
    logic [2:0] g;
    req = 3'b011;
    for (int i = 0; i < 19; i++) begin
      g = (i <= 8) ? 3'b001 : (i <= 17) ? 3'b010 : 3'b001;
      push_exp(g, 1'b1);
      step((i >= 1 && i <= 8) || (i >= 10 && i <= 17));
      exp_v = sb.pop_front(); got_v = obs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL contention step %0d: got %h expected %h", i, got_v, exp_v);
      end
    end
  endtask

  // Rows are {tick, req, expected gnt}.
  task automatic test_early_release;
    logic [6:0] tbl [9] = '{
      7'b1_101_001, 7'b1_101_001, 7'b1_100_100, 7'b0_100_100, 7'b0_000_000,
      7'b0_001_001, 7'b0_000_000, 7'b0_111_010, 7'b0_000_000};
    logic [6:0] row;
    for (int i = 0; i < 9; i++) begin
      row = tbl[i];
      req = row[5:3];
      push_exp(row[2:0], row[2:0] != 3'b000);
      step(row[6]);
      exp_v = sb.pop_front(); got_v = obs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL early_release step %0d: got %h expected %h", i, got_v, exp_v);
      end
    end
  endtask

  // Rows are {tick, blink, req, expected gnt, expected en_7seg}.
  task automatic test_blink;
    logic [10:0] tbl [21] = '{
      11'b0_010_010_010_1, 11'b1_010_010_010_1, 11'b1_010_010_010_1,
      11'b1_010_010_010_1, 11'b1_010_010_010_0, 11'b1_010_010_010_0,
      11'b1_010_010_010_0, 11'b0_000_010_010_1, 11'b0_010_010_010_0,
      11'b1_010_010_010_0, 11'b1_010_010_010_1, 11'b1_010_010_010_1,
      11'b1_010_010_010_1, 11'b1_010_010_010_1, 11'b1_010_010_010_0,
      11'b1_011_011_001_1, 11'b1_011_011_001_1, 11'b1_011_011_001_1,
      11'b1_011_011_001_1, 11'b1_011_011_001_0, 11'b0_011_000_000_0};
    logic [10:0] row;
    for (int i = 0; i < 21; i++) begin
      row = tbl[i];
      blink = row[9:7];
      req   = row[6:4];
      push_exp(row[3:1], row[0]);
      step(row[10]);
      exp_v = sb.pop_front(); got_v = obs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL blink step %0d: got %h expected %h", i, got_v, exp_v);
      end
    end
    blink = '0;
  endtask

  task automatic test_reset_mid;
    req = 3'b011;
    push_exp(3'b010, 1'b1);
    step(1'b0);
    exp_v = sb.pop_front(); got_v = obs(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL reset_mid grant: got %h expected %h", got_v, exp_v);
    end
    rst_n = 1'b0;
    #1;
    push_exp(3'b000, 1'b0);
    exp_v = sb.pop_front(); got_v = obs(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL reset_mid async: got %h expected %h", got_v, exp_v);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req = (i < 2) ? 3'b011 : 3'b000;
      push_exp((i < 2) ? 3'b001 : 3'b000, i < 2);
      step(1'b0);
      exp_v = sb.pop_front(); got_v = obs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid after step %0d: got %h expected %h", i, got_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_contention();
    test_early_release();
    test_blink();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
